// File: rtl/pool_channel_arbiter_if.sv
// Channel request, pooling datapath and tagged result signals
// shared between the channel arbiter and its surroundings.
interface pool_channel_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ROWS   = 24,
  parameter int DW     = 16
);
  localparam int CHW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]         req_valid;
  logic [NUM_CH-1:0]         req_ready;
  logic [NUM_CH*ROWS*DW-1:0] req_column;
  logic                      pool_valid_in;
  logic [ROWS*DW-1:0]        pool_column;
  logic                      pool_valid_out;
  logic [(ROWS/2)*DW-1:0]    pool_result;
  logic                      out_valid;
  logic [(ROWS/2)*DW-1:0]    out_column;
  logic [CHW-1:0]            out_ch;
  logic                      out_last;
  logic                      err_orphan;

  modport master (
    output req_valid, req_column,
    output pool_valid_out, pool_result,
    input  req_ready, pool_valid_in, pool_column,
    input  out_valid, out_column, out_ch,
    input  out_last, err_orphan
  );

  modport slave (
    input  req_valid, req_column,
    input  pool_valid_out, pool_result,
    output req_ready, pool_valid_in, pool_column,
    output out_valid, out_column, out_ch,
    output out_last, err_orphan
  );
endinterface

// File: rtl/pool_channel_arbiter.sv
// Round-robin arbiter granting a shared 2x2 pooling column datapath
// one column pair at a time, tagging each result with channel/last.
module pool_channel_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ROWS   = 24,
  parameter int DW     = 16,
  parameter int COLS   = 24,
  parameter int TAGQ   = 2
) (
  input logic clk,
  input logic rst,
  pool_channel_arbiter_if.slave bus
);
  localparam int CHW = $clog2(NUM_CH);
  localparam int CW  = $clog2(COLS);
  localparam int QW  = (TAGQ > 1) ? $clog2(TAGQ) : 1;
  localparam int NW  = $clog2(TAGQ + 1);
  localparam int CWD = ROWS * DW;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND
  } state_t;

  state_t          state;
  logic [CHW-1:0]  grant;
  logic [CHW-1:0]  rr_ptr;
  logic [CHW-1:0]  pick;
  logic [CHW-1:0]  scan;
  logic            pick_ok;
  logic [CW-1:0]   cnt [NUM_CH];
  logic [CHW-1:0]  q_ch [TAGQ];
  logic            q_last [TAGQ];
  logic [QW-1:0]   rd_ptr;
  logic [QW-1:0]   wr_ptr;
  logic [NW-1:0]   q_cnt;
  logic            xfer;
  logic            push;
  logic            pop;
  logic            q_empty;
  logic            q_full;
  logic            tag_last;
  logic            err;
  logic [CWD-1:0]  sel_col;

  function automatic logic [QW-1:0] q_inc(
    input logic [QW-1:0] p
  );
    return (int'(p) == TAGQ - 1) ? '0 : p + 1'b1;
  endfunction

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    scan    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      scan = CHW'((int'(rr_ptr) + i) % NUM_CH);
      if (bus.req_valid[scan]) begin
        pick_ok = 1'b1;
        pick    = scan;
      end
    end
  end

  always_comb begin
    sel_col       = '0;
    bus.req_ready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant == CHW'(c)) begin
        sel_col          = bus.req_column[c*CWD +: CWD];
        bus.req_ready[c] = (state != IDLE);
      end
    end
  end

  assign q_empty  = (q_cnt == '0);
  assign q_full   = (q_cnt == NW'(TAGQ));
  assign xfer     = (state != IDLE) && bus.req_valid[grant];
  assign push     = xfer && (state == SECOND);
  assign pop      = bus.pool_valid_out && !q_empty;
  assign tag_last = (cnt[grant] == CW'(COLS - 1));

  assign bus.out_valid  = bus.pool_valid_out;
  assign bus.out_column = bus.pool_result;
  assign bus.out_ch     = q_empty ? '0 : q_ch[rd_ptr];
  assign bus.out_last   = !q_empty && q_last[rd_ptr];
  assign bus.err_orphan = err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      grant             <= '0;
      rr_ptr            <= '0;
      bus.pool_valid_in <= 1'b0;
      bus.pool_column   <= '0;
      err               <= 1'b0;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      q_cnt             <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      for (int q = 0; q < TAGQ; q++) begin
        q_ch[q]   <= '0;
        q_last[q] <= 1'b0;
      end
    end else begin
      bus.pool_valid_in <= xfer;
      if (xfer) begin
        bus.pool_column <= sel_col;
        cnt[grant] <= tag_last ? '0 : cnt[grant] + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (pick_ok && !q_full) begin
            grant <= pick;
            state <= FIRST;
          end
        end
        FIRST: begin
          if (xfer) state <= SECOND;
        end
        SECOND: begin
          if (xfer) begin
            state  <= IDLE;
            rr_ptr <= (grant == CHW'(NUM_CH - 1)) ?
                      '0 : grant + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        q_ch[wr_ptr]   <= grant;
        q_last[wr_ptr] <= tag_last;
        wr_ptr         <= q_inc(wr_ptr);
      end
      if (pop) rd_ptr <= q_inc(rd_ptr);
      if (push && !pop) q_cnt <= q_cnt + 1'b1;
      else if (pop && !push) q_cnt <= q_cnt - 1'b1;

      if (bus.pool_valid_out && q_empty) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pool_channel_arbiter.sv
// Directed bench for pool_channel_arbiter with a 2x2 max-pool
// datapath model and per-channel column requesters.
module tb_pool_channel_arbiter;
  localparam int NUM_CH = 4;
  localparam int ROWS   = 24;
  localparam int DW     = 16;
  localparam int COLS   = 24;
  localparam int TAGQ   = 2;
  localparam int CWD    = ROWS * DW;
  localparam int RWD    = (ROWS / 2) * DW;

  typedef logic [CWD-1:0] w_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pool_channel_arbiter_if #(
    .NUM_CH(NUM_CH), .ROWS(ROWS), .DW(DW)
  ) bus ();

  pool_channel_arbiter #(
    .NUM_CH(NUM_CH), .ROWS(ROWS), .DW(DW),
    .COLS(COLS), .TAGQ(TAGQ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int sent [NUM_CH];
  int limit [NUM_CH];
  int rdy_cnt [NUM_CH];
  int n_chk = 0;
  int n_pass = 0;
  int pvi_bad = 0;
  int hot_bad = 0;

  logic           auto_ret;
  logic           man_vo;
  logic [RWD-1:0] man_res;
  logic           model_vo;
  logic [RWD-1:0] model_res;
  logic           phase;
  logic [CWD-1:0] c0;
  logic           acc_prev = 1'b0;
  logic [CWD-1:0] acc_col_prev;

  int             acc_ch_q [$];
  int             out_ch_q [$];
  logic           out_last_q [$];
  logic [RWD-1:0] out_col_q [$];

  function automatic logic [CWD-1:0] col_data(
    input int c, input int idx
  );
    logic [CWD-1:0] v;
    for (int r = 0; r < ROWS; r++)
      v[r*DW +: DW] = {4'(c), 12'((idx * 37 + r * 11) % 4096)};
    return v;
  endfunction

  function automatic logic [RWD-1:0] pool2(
    input logic [CWD-1:0] a, input logic [CWD-1:0] b
  );
    logic [RWD-1:0] v;
    logic [DW-1:0]  m;
    for (int r = 0; r < ROWS / 2; r++) begin
      m = a[2*r*DW +: DW];
      if (a[(2*r+1)*DW +: DW] > m) m = a[(2*r+1)*DW +: DW];
      if (b[2*r*DW +: DW] > m) m = b[2*r*DW +: DW];
      if (b[(2*r+1)*DW +: DW] > m) m = b[(2*r+1)*DW +: DW];
      v[r*DW +: DW] = m;
    end
    return v;
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      bus.req_valid[c] = (sent[c] < limit[c]);
      bus.req_column[c*CWD +: CWD] = col_data(c, sent[c]);
    end
  end

  assign bus.pool_valid_out = model_vo | man_vo;
  assign bus.pool_result    = man_vo ? man_res : model_res;

  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++)
      if (bus.req_valid[c] && bus.req_ready[c])
        sent[c] <= sent[c] + 1;
  end

  // Datapath model: result one cycle after the second column strobe.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase     <= 1'b0;
      model_vo  <= 1'b0;
      model_res <= '0;
      c0        <= '0;
    end else begin
      model_vo <= 1'b0;
      if (bus.pool_valid_in) begin
        if (!phase) begin
          c0    <= bus.pool_column;
          phase <= 1'b1;
        end else begin
          phase     <= 1'b0;
          model_res <= pool2(c0, bus.pool_column);
          model_vo  <= auto_ret;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      acc_prev <= 1'b0;
    end else begin
      if (bus.pool_valid_in !== acc_prev ||
          (acc_prev && bus.pool_column !== acc_col_prev))
        pvi_bad <= pvi_bad + 1;
      if ($countones(bus.req_ready) > 1) hot_bad <= hot_bad + 1;
      acc_prev <= |(bus.req_valid & bus.req_ready);
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.req_ready[c]) rdy_cnt[c] <= rdy_cnt[c] + 1;
        if (bus.req_valid[c] && bus.req_ready[c]) begin
          acc_ch_q.push_back(c);
          acc_col_prev <= bus.req_column[c*CWD +: CWD];
        end
      end
      if (bus.out_valid) begin
        out_ch_q.push_back(int'(bus.out_ch));
        out_last_q.push_back(bus.out_last);
        out_col_q.push_back(bus.out_column);
      end
    end
  end

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sent(input int c, input int n, input string tag);
    int k = 0;
    while (sent[c] < n && k < 500) begin
      step();
      k++;
    end
    chk(tag, w_t'(sent[c] >= n), w_t'(1));
  endtask

  task automatic wait_outs(input int n, input string tag);
    int k = 0;
    while (out_ch_q.size() < n && k < 500) begin
      step();
      k++;
    end
    chk(tag, w_t'(out_ch_q.size() >= n), w_t'(1));
  endtask

  task automatic exp_out(
    input int k, input string tag, input int ch,
    input logic last, input int ia, input int ib
  );
    chk({tag, "_ch"}, w_t'(out_ch_q[k]), w_t'(ch));
    chk({tag, "_last"}, w_t'(out_last_q[k]), w_t'(last));
    chk({tag, "_col"}, w_t'(out_col_q[k]),
        w_t'(pool2(col_data(ch, ia), col_data(ch, ib))));
  endtask

  function automatic int rdy_sum();
    int s = 0;
    for (int c = 0; c < NUM_CH; c++) s += rdy_cnt[c];
    return s;
  endfunction

  initial begin
    int ob;
    int ab;
    int snap;
    int k;
    man_vo   = 1'b0;
    man_res  = '0;
    auto_ret = 1'b1;
    repeat (3) step();
    chk("rst_ready", w_t'(bus.req_ready), w_t'(0));
    chk("rst_pvi", w_t'(bus.pool_valid_in), w_t'(0));
    chk("rst_pcol", w_t'(bus.pool_column), w_t'(0));
    chk("rst_err", w_t'(bus.err_orphan), w_t'(0));
    chk("rst_och", w_t'(bus.out_ch), w_t'(0));
    chk("rst_olast", w_t'(bus.out_last), w_t'(0));
    step();
    rst = 1'b1;

    // ch0 streams one full map
    limit[0] = 24;
    wait_sent(0, 24, "s1_sent");
    wait_outs(12, "s1_outs");
    for (int j = 0; j < 12; j++)
      exp_out(j, $sformatf("s1_%0d", j), 0, j == 11, 2*j, 2*j+1);

    // ch1 reset while waiting for the second column of a pair
    ob = out_ch_q.size();
    limit[1] = 7;
    wait_sent(1, 7, "s6_sent7");
    chk("s6_pre_ready", w_t'(bus.req_ready), w_t'(4'b0010));
    chk("s6_pre_pvi", w_t'(bus.pool_valid_in), w_t'(1));
    chk("s6_pre_outs", w_t'(out_ch_q.size()), w_t'(ob + 3));
    for (int j = 0; j < 3; j++)
      exp_out(ob + j, $sformatf("s6a_%0d", j), 1, 1'b0, 2*j, 2*j+1);
    rst = 1'b0;
    #1;
    chk("s6_rst_ready", w_t'(bus.req_ready), w_t'(0));
    chk("s6_rst_pvi", w_t'(bus.pool_valid_in), w_t'(0));
    step();
    rst = 1'b1;
    ob = out_ch_q.size();
    limit[1] = 31;
    wait_sent(1, 31, "s6_sent");
    wait_outs(ob + 12, "s6_outs");
    for (int j = 0; j < 12; j++)
      exp_out(ob + j, $sformatf("s6b_%0d", j), 1, j == 11,
              7 + 2*j, 8 + 2*j);

    // ch1 and ch3 contend; rr_ptr is 2 after ch1's last pair
    ob = out_ch_q.size();
    ab = acc_ch_q.size();
    snap = rdy_cnt[0] + rdy_cnt[2];
    limit[1] = 39;
    limit[3] = 8;
    wait_sent(1, 39, "s2_sent1");
    wait_sent(3, 8, "s2_sent3");
    wait_outs(ob + 8, "s2_outs");
    for (int j = 0; j < 16; j++)
      chk($sformatf("s2_acc_%0d", j), w_t'(acc_ch_q[ab + j]),
          w_t'(((j / 2) % 2 == 0) ? 3 : 1));
    chk("s2_rdy02", w_t'(rdy_cnt[0] + rdy_cnt[2]), w_t'(snap));
    for (int j = 0; j < 8; j++) begin
      if (j % 2 == 0)
        exp_out(ob + j, $sformatf("s2_%0d", j), 3, 1'b0, j, j + 1);
      else
        exp_out(ob + j, $sformatf("s2_%0d", j), 1, 1'b0,
                31 + j - 1, 31 + j);
    end

    // ch2 stalls mid-pair while ch0 waits
    ob = out_ch_q.size();
    ab = acc_ch_q.size();
    limit[2] = 1;
    wait_sent(2, 1, "s3_first");
    limit[0] = 26;
    snap = rdy_cnt[0];
    repeat (5) step();
    chk("s3_lock_rdy0", w_t'(rdy_cnt[0]), w_t'(snap));
    chk("s3_lock_sent0", w_t'(sent[0]), w_t'(24));
    chk("s3_lock_ready", w_t'(bus.req_ready), w_t'(4'b0100));
    limit[2] = 2;
    wait_sent(0, 26, "s3_sent0");
    wait_outs(ob + 2, "s3_outs");
    chk("s3_acc0", w_t'(acc_ch_q[ab]), w_t'(2));
    chk("s3_acc1", w_t'(acc_ch_q[ab + 1]), w_t'(2));
    chk("s3_acc2", w_t'(acc_ch_q[ab + 2]), w_t'(0));
    chk("s3_acc3", w_t'(acc_ch_q[ab + 3]), w_t'(0));
    exp_out(ob, "s3_r0", 2, 1'b0, 0, 1);
    exp_out(ob + 1, "s3_r1", 0, 1'b0, 24, 25);

    // tag queue fills with results withheld
    auto_ret = 1'b0;
    limit[2] = 6;
    limit[3] = 10;
    wait_sent(3, 10, "s4_sent3");
    wait_sent(2, 4, "s4_sent2");
    snap = rdy_sum();
    repeat (8) step();
    chk("s4_full_sent2", w_t'(sent[2]), w_t'(4));
    chk("s4_full_rdy", w_t'(rdy_sum()), w_t'(snap));
    chk("s4_full_ready", w_t'(bus.req_ready), w_t'(0));
    man_vo  = 1'b1;
    man_res = {12{16'hA1A1}};
    #1;
    chk("s4_p1_valid", w_t'(bus.out_valid), w_t'(1));
    chk("s4_p1_ch", w_t'(bus.out_ch), w_t'(2));
    chk("s4_p1_last", w_t'(bus.out_last), w_t'(0));
    chk("s4_p1_col", w_t'(bus.out_column), w_t'({12{16'hA1A1}}));
    step();
    man_vo = 1'b0;
    k = 0;
    while (!(sent[2] == 5 && bus.req_ready[2]) && k < 50) begin
      step();
      k++;
    end
    chk("s4_resume", w_t'(sent[2] == 5 && bus.req_ready[2]), w_t'(1));
    man_vo  = 1'b1;
    man_res = {12{16'hB2B2}};
    #1;
    chk("s4_p2_ch", w_t'(bus.out_ch), w_t'(3));
    step();
    man_vo = 1'b0;
    #1;
    chk("s4_after_ch", w_t'(bus.out_ch), w_t'(2));
    chk("s4_after_sent2", w_t'(sent[2]), w_t'(6));
    step();
    man_vo  = 1'b1;
    man_res = {12{16'hC3C3}};
    #1;
    chk("s4_p3_ch", w_t'(bus.out_ch), w_t'(2));
    chk("s4_p3_last", w_t'(bus.out_last), w_t'(0));
    step();
    man_vo = 1'b0;
    #1;
    chk("s4_empty_ch", w_t'(bus.out_ch), w_t'(0));
    chk("s4_err", w_t'(bus.err_orphan), w_t'(0));

    // result with an empty tag queue
    step();
    man_vo  = 1'b1;
    man_res = {12{16'hD4D4}};
    #1;
    chk("s5_valid", w_t'(bus.out_valid), w_t'(1));
    chk("s5_ch", w_t'(bus.out_ch), w_t'(0));
    chk("s5_last", w_t'(bus.out_last), w_t'(0));
    chk("s5_col", w_t'(bus.out_column), w_t'({12{16'hD4D4}}));
    chk("s5_err_pre", w_t'(bus.err_orphan), w_t'(0));
    step();
    man_vo = 1'b0;
    #1;
    chk("s5_err_set", w_t'(bus.err_orphan), w_t'(1));
    auto_ret = 1'b1;
    ob = out_ch_q.size();
    limit[0] = 28;
    wait_sent(0, 28, "s5_sent0");
    wait_outs(ob + 1, "s5_outs");
    exp_out(ob, "s5_r0", 0, 1'b0, 26, 27);
    repeat (2) step();
    chk("s5_err_hold", w_t'(bus.err_orphan), w_t'(1));

    chk("pvi_timing", w_t'(pvi_bad), w_t'(0));
    chk("ready_onehot", w_t'(hot_bad), w_t'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
